prng_range_gen: RTL and testbench

- Parametrised successor to the team's 4-bit LFSR random source for the matrix calculator.
- Generates uniformly distributed random values in a requested inclusive range [lo, hi] using rejection sampling, with a bounded-latency modulo fallback.
- Adds a valid/ready request/response handshake, runtime reseeding and a selectable LFSR width.
- Feeds the random-matrix fill path, which issues one request per matrix element.

---
 rtl/prng_pkg.sv | 24 ++
 rtl/lfsr_core.sv | 36 +++
 rtl/prng_range_gen.sv | 159 +++++++++++++++
 tb/tb_prng_range_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared definitions for the range-limited random generator:
// FSM state encoding, LFSR tap masks and the feedback-bit helper.
package prng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Tap masks: bit set = bit participates in the XOR feedback.
    localparam logic [15:0] TAPS16 = 16'hB400;      // 15,13,12,10
    localparam logic [31:0] TAPS32 = 32'h80200003;  // 31,21,1,0

    // Feedback bit for a register of width w (16 or 32). Narrower
    // registers are passed zero-extended in v.
    function automatic logic lfsr_fb(input logic [31:0] v, input int w);
        if (w == 32)
            return ^(v & TAPS32);
        else
            return ^(v[15:0] & TAPS16);
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Fibonacci LFSR with synchronous seed load.
// A zero seed would lock the register up, so it is replaced by SEED.
module lfsr_core
    import prng_pkg::*;
#(
    parameter int            W    = 16,
    parameter logic [W-1:0]  SEED = W'(16'hACE1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_load,
    input  logic [W-1:0] seed_in,
    output logic [W-1:0] lfsr
);

    if (!(W == 16 || W == 32)) begin : g_bad_width
        $error("lfsr_core: W must be 16 or 32");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_core: SEED must be nonzero");
    end

    logic fb;
    assign fb = lfsr_fb(32'(lfsr), W);

    // Seed load has priority over the shift; a zero seed falls back to SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= SEED;
        else if (seed_load)
            lfsr <= (seed_in == '0) ? SEED : seed_in;
        else
            lfsr <= {lfsr[W-2:0], fb};
    end

endmodule

// File: rtl/prng_range_gen.sv
// Uniform random value generator over an inclusive range [lo, hi].
// Rejection sampling on the LFSR low bits; after MAX_REJECT misses the
// last candidate is folded into range with a modulo (rsp_fallback=1).
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high; valid, once raised, holds its payload stable
// until that edge; ready never depends combinationally on valid.
// Optional build macro: PRNG_STATS_EN enables the saturating reject_cnt.
module prng_range_gen
    import prng_pkg::*;
#(
    parameter int                 LFSR_W     = 16,
    parameter int                 OUT_W      = 4,
    parameter logic [LFSR_W-1:0]  SEED       = LFSR_W'(16'hACE1),
    parameter int                 MAX_REJECT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OUT_W-1:0]  lo,
    input  logic [OUT_W-1:0]  hi,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [OUT_W-1:0]  rsp_value,
    output logic              rsp_fallback,
    output logic [15:0]       reject_cnt,
    output state_t            dbg_state,
    output logic [LFSR_W-1:0] dbg_lfsr
);

    if (OUT_W < 1 || OUT_W > LFSR_W) begin : g_bad_out_w
        $error("prng_range_gen: OUT_W must be in 1..LFSR_W");
    end
    if (MAX_REJECT < 1) begin : g_bad_max_reject
        $error("prng_range_gen: MAX_REJECT must be at least 1");
    end

    localparam int              CNT_W     = (MAX_REJECT > 1) ? $clog2(MAX_REJECT) : 1;
    localparam logic [CNT_W-1:0] LAST_DRAW = CNT_W'(MAX_REJECT - 1);

    logic [LFSR_W-1:0] lfsr;

    lfsr_core #(
        .W    (LFSR_W),
        .SEED (SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .lfsr      (lfsr)
    );

    state_t           state;
    logic [OUT_W-1:0] lo_q;
    logic [OUT_W-1:0] hi_q;
    logic [OUT_W:0]   span_q;
    logic [CNT_W-1:0] draw_cnt;

    logic [OUT_W-1:0] cand;
    logic [OUT_W-1:0] lo_d;
    logic [OUT_W-1:0] hi_d;
    logic [OUT_W:0]   span_d;
    logic [OUT_W-1:0] fb_val;
    logic             in_range;
    logic             last_draw;
    logic             rejecting;

    // Candidate is the LFSR low bits as they stand in the draw cycle.
    assign cand      = lfsr[OUT_W-1:0];
    assign lo_d      = (lo <= hi) ? lo : hi;
    assign hi_d      = (lo <= hi) ? hi : lo;
    // One bit wider so a full-range request yields 2^OUT_W.
    assign span_d    = {1'b0, hi_d} - {1'b0, lo_d} + (OUT_W+1)'(1);
    assign in_range  = (cand >= lo_q) && (cand <= hi_q);
    assign last_draw = (draw_cnt == LAST_DRAW);
    // (cand mod span) < span, so L + it never exceeds H and fits OUT_W bits.
    assign fb_val    = OUT_W'(({1'b0, cand} % span_q) + {1'b0, lo_q});
    assign rejecting = (state == DRAW) && !in_range && !last_draw;

    assign dbg_state = state;
    assign dbg_lfsr  = lfsr;

    // Request/draw/hold controller with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_value    <= '0;
            rsp_fallback <= 1'b0;
            lo_q         <= '0;
            hi_q         <= '0;
            span_q       <= (OUT_W+1)'(1);
            draw_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lo_q      <= lo_d;
                        hi_q      <= hi_d;
                        span_q    <= span_d;
                        draw_cnt  <= '0;
                        req_ready <= 1'b0;
                        state     <= DRAW;
                    end
                end
                DRAW: begin
                    if (in_range) begin
                        rsp_value    <= cand;
                        rsp_fallback <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= HOLD;
                    end else if (last_draw) begin
                        rsp_value    <= fb_val;
                        rsp_fallback <= 1'b1;
                        rsp_valid    <= 1'b1;
                        state        <= HOLD;
                    end else begin
                        draw_cnt <= draw_cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef PRNG_STATS_EN
    logic [15:0] rej_q;

    // Count rejected draws, excluding the one that triggers the fallback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rej_q <= 16'h0000;
        else if (rejecting && rej_q != 16'hFFFF)
            rej_q <= rej_q + 16'd1;
    end

    assign reject_cnt = rej_q;
`else
    logic unused_rejecting;
    assign unused_rejecting = rejecting;
    assign reject_cnt       = 16'h0000;
`endif

endmodule

// File: tb/tb_prng_range_gen.sv
// Directed/random bench for prng_range_gen (LFSR_W=16, OUT_W=4, MAX_REJECT=8).
// A cycle model pushes {fallback, value} into exp_q when it resolves a draw;
// the driver pops and compares when the DUT presents rsp_valid.
module tb_prng_range_gen;
    import prng_pkg::*;

    localparam int          OUT_W      = 4;
    localparam int          MAX_REJECT = 8;
    localparam logic [15:0] SEED_V     = 16'hACE1;
`ifdef PRNG_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              seed_load = 1'b0;
    logic [15:0]       seed_in = '0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [OUT_W-1:0]  lo = '0;
    logic [OUT_W-1:0]  hi = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [OUT_W-1:0]  rsp_value;
    logic              rsp_fallback;
    logic [15:0]       reject_cnt;
    state_t            dbg_state;
    logic [15:0]       dbg_lfsr;

    prng_range_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seed_load    (seed_load),
        .seed_in      (seed_in),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .lo           (lo),
        .hi           (hi),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_value    (rsp_value),
        .rsp_fallback (rsp_fallback),
        .reject_cnt   (reject_cnt),
        .dbg_state    (dbg_state),
        .dbg_lfsr     (dbg_lfsr)
    );

    // ---------------- scoreboard ----------------
    logic [OUT_W:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- cycle model ----------------
    logic [15:0] m_lfsr;
    state_t      m_state;
    logic [3:0]  m_lo, m_hi;
    int          m_cnt;
    logic [15:0] m_rej;
    int          m_span;
    logic [3:0]  m_cand;
    logic        m_hit;
    logic [3:0]  m_fbv;
    logic        m_tap;

    assign m_cand = m_lfsr[3:0];
    assign m_hit  = (m_cand >= m_lo) && (m_cand <= m_hi);
    assign m_span = int'(m_hi) - int'(m_lo) + 1;
    assign m_fbv  = 4'(int'(m_lo) + (int'(m_cand) % m_span));
    assign m_tap  = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr  <= SEED_V;
            m_state <= IDLE;
            m_lo    <= '0;
            m_hi    <= '0;
            m_cnt   <= 0;
            m_rej   <= '0;
            exp_q.delete();
        end else begin
            m_lfsr <= seed_load ? ((seed_in == 16'h0) ? SEED_V : seed_in)
                                : {m_lfsr[14:0], m_tap};
            case (m_state)
                IDLE: if (req_valid) begin
                    m_lo    <= (lo < hi) ? lo : hi;
                    m_hi    <= (lo < hi) ? hi : lo;
                    m_cnt   <= 0;
                    m_state <= DRAW;
                end
                DRAW: if (m_hit) begin
                    exp_q.push_back({1'b0, m_cand});
                    m_state <= HOLD;
                end else if (m_cnt == MAX_REJECT - 1) begin
                    exp_q.push_back({1'b1, m_fbv});
                    m_state <= HOLD;
                end else begin
                    m_cnt <= m_cnt + 1;
                    if (m_rej != 16'hFFFF) m_rej <= m_rej + 16'd1;
                end
                HOLD: if (rsp_ready) m_state <= IDLE;
                default: m_state <= IDLE;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    // Present a request and return at the negedge after the handshake edge.
    task automatic issue(input logic [3:0] a, input logic [3:0] b);
        int n;
        lo = a;
        hi = b;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait for the response, compare against the model, stall, then accept.
    task automatic finish_rsp(input int exact_lat, input int stall, output logic [4:0] got);
        int lat;
        logic [4:0] e;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_valid_seen", rsp_valid, 1'b1);
        if (exact_lat > 0) check("latency_exact", lat, exact_lat);
        else               check("latency_bound", (lat <= MAX_REJECT + 1), 1'b1);
        got = {rsp_fallback, rsp_value};
        check("exp_q_nonempty", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_vs_model", got, e);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_stable", {rsp_fallback, rsp_value}, got);
            check("hold_req_ready", req_ready, 1'b0);
            check("hold_rsp_valid", rsp_valid, 1'b1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_req_ready", req_ready, 1'b1);
        check("post_rsp_valid_low", rsp_valid, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    logic [4:0] got;
    int         n_fb5;

    initial begin
        // Reset state
        #12;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_value", rsp_value, 4'h0);
        check("rst_rsp_fallback", rsp_fallback, 1'b0);
        check("rst_reject_cnt", reject_cnt, 16'h0);
        check("rst_state", dbg_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_lfsr", dbg_lfsr, 16'hACE1);
        @(negedge clk);
        check("lfsr_step1", dbg_lfsr, 16'h59C3);

        // Full range: always a first-draw hit, exactly two cycles
        for (int i = 0; i < 6; i++) begin
            issue(4'd0, 4'd15);
            finish_rsp(2, 0, got);
            check("full_no_fallback", got[4], 1'b0);
        end

        // Single-value range
        n_fb5 = 0;
        for (int i = 0; i < 500; i++) begin
            issue(4'd5, 4'd5);
            finish_rsp(0, 0, got);
            check("fixed5_value", got[3:0], 4'd5);
            if (got[4]) n_fb5++;
        end
        check("fixed5_some_fallback", (n_fb5 > 0), 1'b1);
        check("lfsr_tracks_model_a", dbg_lfsr, m_lfsr);

        // Swapped bounds with random stalls and occasional reseeds
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                seed_load = 1'b1;
                seed_in = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
                @(negedge clk);
                seed_load = 1'b0;
            end
            issue(4'd9, 4'd3);
            finish_rsp(0, $urandom_range(0, 2), got);
            check("swap_in_range", (got[3:0] >= 4'd3) && (got[3:0] <= 4'd9), 1'b1);
        end
        check("lfsr_tracks_model_b", dbg_lfsr, m_lfsr);
        check("reject_cnt_total", reject_cnt, STATS ? m_rej : 16'h0);

        // Backpressure: 10 stalled cycles with a pending request held high
        issue(4'd2, 4'd11);
        req_valid = 1'b1;
        finish_rsp(0, 10, got);
        // Response completed with req_valid high; request is taken one cycle later
        check("turnaround_state", dbg_state, IDLE);
        @(negedge clk);
        req_valid = 1'b0;
        check("turnaround_taken", req_ready, 1'b0);
        finish_rsp(0, 0, got);

        // Same-cycle response accept and new request: no same-cycle turnaround
        issue(4'd0, 4'd7);
        finish_rsp(0, 0, got);

        // Zero seed load substitutes SEED
        seed_load = 1'b1;
        seed_in = 16'h0000;
        @(negedge clk);
        seed_load = 1'b0;
        check("seed_zero", dbg_lfsr, 16'hACE1);
        seed_load = 1'b1;
        seed_in = 16'h1234;
        @(negedge clk);
        seed_load = 1'b0;
        check("seed_value", dbg_lfsr, 16'h1234);

        // Reset pulse during DRAW
        issue(4'd5, 4'd5);
        check("pre_reset_draw", dbg_state, DRAW);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_req_ready", req_ready, 1'b1);
        check("mid_rst_state", dbg_state, IDLE);
        check("mid_rst_lfsr", dbg_lfsr, 16'hACE1);
        check("mid_rst_reject_cnt", reject_cnt, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_lfsr", dbg_lfsr, 16'h59C3);
        issue(4'd0, 4'd15);
        finish_rsp(2, 0, got);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
